// File: rtl/serializer_pkg.sv
// Shared types and sizing helpers for the serial transmit path.
package serializer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } ser_state_t;

    // Bits needed to hold values 0..max_val inclusive.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/serializer_tx_bit_tick_gen.sv
// Bit-rate divider: pulses tick_c on the last clock of every CLK_DIV-cycle bit period.
module bit_tick_gen
    import serializer_pkg::*;
#(
    parameter int unsigned CLK_DIV = 10
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    output logic tick_c
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_TC = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    assign tick_c = en && (div_q == DIV_TC);

    // Held at zero outside a frame so every frame starts on a full bit period.
    always_comb begin
        div_d = '0;
        if (en && (div_q != DIV_TC)) begin
            div_d = div_q + DIV_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/serializer_tx.sv
// Parallel-to-serial transmitter: accepts a word on write_in/status_out and shifts it
// out on serial_out, framed by serial_valid and terminated by a done_out pulse.
module serializer_tx
    import serializer_pkg::*;
#(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CLK_DIV   = 10,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              write_in,
    output logic              status_out,
    output logic              serial_out,
    output logic              serial_valid,
    output logic              done_out,
    output logic              err_out
);

    localparam int unsigned BCNT_W = cnt_w(DATA_W);
    localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(DATA_W - 1);

    ser_state_t        state_q, state_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic              status_q, status_d;
    logic              serial_out_q, serial_out_d;
    logic              serial_valid_q, serial_valid_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              tick_c;
    logic [DATA_W-1:0] shifted_c;

    bit_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clock  (clock),
        .reset  (reset),
        .en     (state_q == SHIFT),
        .tick_c (tick_c)
    );

    assign status_out   = status_q;
    assign serial_out   = serial_out_q;
    assign serial_valid = serial_valid_q;
    assign done_out     = done_q;
    assign err_out      = err_q;

    // Serial outputs are precomputed one cycle ahead so every output leaves a flop.
    always_comb begin
        state_d        = state_q;
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        status_d       = 1'b0;
        serial_out_d   = 1'b0;
        serial_valid_d = 1'b0;
        done_d         = 1'b0;
        err_d          = 1'b0;

        if (MSB_FIRST) begin
            shifted_c = {shift_q[DATA_W-2:0], 1'b0};
        end else begin
            shifted_c = {1'b0, shift_q[DATA_W-1:1]};
        end

        unique case (state_q)
            IDLE: begin
                status_d = 1'b1;
                if (write_in) begin
                    state_d        = SHIFT;
                    shift_d        = data_in;
                    bit_cnt_d      = '0;
                    status_d       = 1'b0;
                    serial_valid_d = 1'b1;
                    serial_out_d   = MSB_FIRST ? data_in[DATA_W-1] : data_in[0];
                end
            end
            SHIFT: begin
                err_d          = write_in;
                serial_valid_d = 1'b1;
                serial_out_d   = MSB_FIRST ? shift_q[DATA_W-1] : shift_q[0];
                if (tick_c) begin
                    shift_d   = shifted_c;
                    bit_cnt_d = bit_cnt_q + BCNT_W'(1);
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d        = DONE;
                        serial_valid_d = 1'b0;
                        serial_out_d   = 1'b0;
                        done_d         = 1'b1;
                    end else begin
                        serial_out_d = MSB_FIRST ? shifted_c[DATA_W-1] : shifted_c[0];
                    end
                end
            end
            DONE: begin
                err_d    = write_in;
                state_d  = IDLE;
                status_d = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            status_q       <= 1'b1;
            serial_out_q   <= 1'b0;
            serial_valid_q <= 1'b0;
            done_q         <= 1'b0;
            err_q          <= 1'b0;
        end else begin
            state_q        <= state_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            status_q       <= status_d;
            serial_out_q   <= serial_out_d;
            serial_valid_q <= serial_valid_d;
            done_q         <= done_d;
            err_q          <= err_d;
        end
    end

endmodule

// File: tb/tb_serializer_tx.sv
// Scoreboard bench for serializer_tx: two instances (MSB-first/div-10 and LSB-first/div-1).
module tb_serializer_tx;

    typedef struct {
        int         dut;
        logic [7:0] word;
        int         gap;
    } exp_t;

    logic       clock;
    logic       reset;
    logic [7:0] data0, data6;
    logic       write0, write6;
    logic [1:0] st, so, sv, dn, er;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_err  = 0;

    int         cyc[2], holdbad[2], gap_cnt[2], gap_at_start[2], err_seen[2], done_seen[2];
    logic [7:0] word_acc[2];
    logic       cur_bit[2];
    logic       prev_valid[2];

    serializer_tx #(.DATA_W(8), .CLK_DIV(10), .MSB_FIRST(1'b1)) dut (
        .clock(clock), .reset(reset), .data_in(data0), .write_in(write0),
        .status_out(st[0]), .serial_out(so[0]), .serial_valid(sv[0]),
        .done_out(dn[0]), .err_out(er[0])
    );

    serializer_tx #(.DATA_W(8), .CLK_DIV(1), .MSB_FIRST(1'b0)) dut6 (
        .clock(clock), .reset(reset), .data_in(data6), .write_in(write6),
        .status_out(st[1]), .serial_out(so[1]), .serial_valid(sv[1]),
        .done_out(dn[1]), .err_out(er[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input bit ok, input string name, input int act, input int exp);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int div_of(input int i);
        return (i == 0) ? 10 : 1;
    endfunction

    // Monitor: rebuilds each frame from the serial line and checks it on done_out.
    always @(negedge clock) begin
        exp_t e;
        int   bi;
        int   pos;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                cyc[i] = 0; holdbad[i] = 0; word_acc[i] = '0; cur_bit[i] = 1'b0;
                gap_cnt[i] = 999; gap_at_start[i] = 999; prev_valid[i] = 1'b0;
            end else begin
                if (sv[i]) begin
                    if (!prev_valid[i]) gap_at_start[i] = gap_cnt[i];
                    gap_cnt[i] = 0;
                    bi = cyc[i] / div_of(i);
                    if (bi > 7) begin
                        holdbad[i]++;
                    end else if ((cyc[i] % div_of(i)) == 0) begin
                        pos = (i == 0) ? 7 - bi : bi;
                        word_acc[i][pos] = so[i];
                        cur_bit[i] = so[i];
                    end else if (so[i] != cur_bit[i]) begin
                        holdbad[i]++;
                    end
                    cyc[i]++;
                end else begin
                    gap_cnt[i]++;
                end
                if (er[i]) err_seen[i]++;
                if (dn[i]) begin
                    done_seen[i]++;
                    check(exp_q.size() > 0, "done_expected", exp_q.size(), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check(e.dut == i, "done_dut", i, e.dut);
                        check(word_acc[i] == e.word && holdbad[i] == 0, "frame_word",
                              int'(word_acc[i]) | (holdbad[i] << 8), int'(e.word));
                        check(cyc[i] == 8 * div_of(i), "frame_len", cyc[i], 8 * div_of(i));
                        check(prev_valid[i] && !sv[i], "done_after_last_bit",
                              int'(prev_valid[i]), 1);
                        if (e.gap >= 0) check(gap_at_start[i] == e.gap, "frame_gap",
                                              gap_at_start[i], e.gap);
                    end
                    cyc[i] = 0; holdbad[i] = 0; word_acc[i] = '0;
                end
                prev_valid[i] = sv[i];
            end
        end
    end

    task automatic send0(input logic [7:0] d);
        @(negedge clock);
        data0  = d;
        write0 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        write0 = 1'b0;
    endtask

    task automatic wait_idle0();
        int n = 0;
        while (st[0] !== 1'b1 && n < 300) begin
            @(negedge clock);
            n++;
        end
        check(n < 300, "idle_timeout", n, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t expected < 100000", $time);
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        reset = 1'b1; data0 = '0; data6 = '0; write0 = 1'b0; write6 = 1'b0;
        foreach (err_seen[i]) begin err_seen[i] = 0; done_seen[i] = 0; end
        repeat (3) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);

        // 1: reset state
        for (int i = 0; i < 2; i++) begin
            check(st[i] == 1'b1, "rst_status", st[i], 1);
            check(so[i] == 1'b0, "rst_serial_out", so[i], 0);
            check(sv[i] == 1'b0, "rst_serial_valid", sv[i], 0);
            check(dn[i] == 1'b0, "rst_done", dn[i], 0);
            check(er[i] == 1'b0, "rst_err", er[i], 0);
        end

        // 2: single frame A5, latency of done/status
        exp_q.push_back('{0, 8'hA5, -1});
        send0(8'hA5);
        check(st[0] == 1'b0, "busy_after_accept", st[0], 0);
        check(sv[0] == 1'b1 && so[0] == 1'b1, "first_bit_latency", {sv[0], so[0]}, 3);
        repeat (79) @(negedge clock);
        check(dn[0] == 1'b0 && sv[0] == 1'b1, "cycle80", {dn[0], sv[0]}, 1);
        @(negedge clock);
        check(dn[0] == 1'b1 && st[0] == 1'b0, "done_cycle81", {dn[0], st[0]}, 2);
        @(negedge clock);
        check(st[0] == 1'b1 && dn[0] == 1'b0, "status_cycle82", {st[0], dn[0]}, 2);

        // 3: write while busy during bit 3 of 3C
        exp_q.push_back('{0, 8'h3C, -1});
        send0(8'h3C);
        repeat (32) @(negedge clock);
        data0 = 8'hFF; write0 = 1'b1;
        exp_err += 1;
        @(negedge clock);
        write0 = 1'b0;
        check(er[0] == 1'b1, "err_pulse", er[0], 1);
        @(negedge clock);
        check(er[0] == 1'b0, "err_one_cycle", er[0], 0);
        wait_idle0();
        repeat (3) @(negedge clock);

        // 4: held write_in, back-to-back C3 then 81
        base = done_seen[0];
        exp_q.push_back('{0, 8'hC3, -1});
        exp_q.push_back('{0, 8'h81, 2});
        @(negedge clock);
        data0 = 8'hC3; write0 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        data0 = 8'h81;
        n = 0;
        while (st[0] !== 1'b1 && n < 300) begin
            @(negedge clock);
            n++;
        end
        check(n < 300, "held_idle_timeout", n, 0);
        @(posedge clock);
        @(negedge clock);
        write0 = 1'b0;
        exp_err += 81;
        check(st[0] == 1'b0 && sv[0] == 1'b1, "second_accept", {st[0], sv[0]}, 1);
        wait_idle0();
        repeat (3) @(negedge clock);
        check(done_seen[0] - base == 2, "held_done_count", done_seen[0] - base, 2);

        // 5: reset during bit 4 of F0, then clean 0F
        base = done_seen[0];
        send0(8'hF0);
        repeat (44) @(negedge clock);
        reset = 1'b1;
        #1;
        check(st[0] == 1'b1 && sv[0] == 1'b0 && so[0] == 1'b0 && dn[0] == 1'b0,
              "reset_midframe", {st[0], sv[0], so[0], dn[0]}, 8);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        repeat (3) @(negedge clock);
        check(done_seen[0] == base, "no_partial_done", done_seen[0] - base, 0);
        exp_q.push_back('{0, 8'h0F, -1});
        send0(8'h0F);
        wait_idle0();
        repeat (2) @(negedge clock);
        check(done_seen[0] - base == 1, "post_reset_done", done_seen[0] - base, 1);

        // 6: LSB first, one bit per cycle, 01
        exp_q.push_back('{1, 8'h01, -1});
        @(negedge clock);
        data6 = 8'h01; write6 = 1'b1;
        @(posedge clock);
        @(negedge clock);
        write6 = 1'b0;
        check(so[1] == 1'b1 && sv[1] == 1'b1, "lsb_first_bit", {sv[1], so[1]}, 3);
        @(negedge clock);
        check(so[1] == 1'b0, "lsb_second_bit", so[1], 0);
        repeat (6) @(negedge clock);
        check(dn[1] == 1'b0 && sv[1] == 1'b1, "div1_cycle8", {dn[1], sv[1]}, 1);
        @(negedge clock);
        check(dn[1] == 1'b1, "div1_done_cycle9", dn[1], 1);
        repeat (4) @(negedge clock);

        check(exp_q.size() == 0, "scoreboard_empty", exp_q.size(), 0);
        check(err_seen[0] == exp_err, "err_cycles_dut0", err_seen[0], exp_err);
        check(err_seen[1] == 0, "err_cycles_dut1", err_seen[1], 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
